// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI RAM master controller:
// frame header codes, FSM encoding and default timing.
package spi_ctrl_pkg;

   localparam int HDR_W = 3;

   localparam logic [HDR_W-1:0] HDR_WADDR = 3'b000;
   localparam logic [HDR_W-1:0] HDR_WDATA = 3'b001;
   localparam logic [HDR_W-1:0] HDR_RADDR = 3'b110;
   localparam logic [HDR_W-1:0] HDR_RDATA = 3'b111;

   localparam int DEF_ADDR_SIZE  = 8;
   localparam int DEF_TURNAROUND = 2;
   localparam int DEF_GAP        = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_HDR,
      ST_PAYLOAD,
      ST_TAIL,
      ST_TURN,
      ST_RX,
      ST_GAP
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_bit_shifter.sv
// Header+payload serializer and MISO deserializer
// for the SPI RAM master controller.
module spi_bit_shifter
   import spi_ctrl_pkg::*;
#(
   parameter int W = DEF_ADDR_SIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [W+HDR_W-1:0] i_frame,
   input  logic             i_shift,
   output logic             o_msb,
   input  logic             i_rx_en,
   input  logic             i_rx_bit,
   output logic [W-1:0]     o_rx_next
);

   localparam int FW = W + HDR_W;

   logic [FW-1:0] r_tx;
   logic [W-1:0]  r_rx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx <= '0;
         r_rx <= '0;
      end else begin
         if (i_load)
            r_tx <= i_frame;
         else if (i_shift)
            r_tx <= {r_tx[FW-2:0], 1'b0};
         if (i_rx_en)
            r_rx <= o_rx_next;
      end
   end

   assign o_msb     = r_tx[FW-1];
   assign o_rx_next = {r_rx[W-2:0], i_rx_bit};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI RAM master: turns write/read requests into
// two-frame SPI transactions on SS_n/MOSI/MISO.
module spi_master_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
   parameter int TURNAROUND = DEF_TURNAROUND,
   parameter int GAP        = DEF_GAP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [ADDR_SIZE-1:0] req_wdata,
   output logic                 rd_valid,
   output logic [ADDR_SIZE-1:0] rd_data,
   output logic                 wr_done,
   output logic                 busy,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO
);

   localparam int W     = ADDR_SIZE;
   localparam int MAXV  =
      max2(max2(W, HDR_W), max2(TURNAROUND, GAP));
   localparam int CNT_W = $clog2(MAXV + 1);

   localparam logic [CNT_W-1:0] C_HDR  = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] C_BITS = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0] C_TURN =
      CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
   localparam logic [CNT_W-1:0] C_GAP  =
      CNT_W'((GAP > 0) ? GAP - 1 : 0);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_second;
   logic             r_write;
   logic [W-1:0]     r_addr;
   logic [W-1:0]     r_wdata;
   logic             r_ss_n;
   logic             r_mosi;
   logic             r_rd_valid;
   logic [W-1:0]     r_rd_data;
   logic             r_wr_done;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_second_nxt;
   logic             w_capture;
   logic             w_load;
   logic             w_shift;
   logic             w_rx_en;
   logic             w_wr_done_nxt;
   logic             w_rd_valid_nxt;
   logic             w_cnt_zero;
   logic             w_first;
   logic             w_wr;
   logic [HDR_W-1:0] w_hdr;
   logic [W-1:0]     w_payload;
   logic             w_msb;
   logic [W-1:0]     w_rx_next;

   // Frame 1 is loaded at accept straight from req_*,
   // frame 2 from the captured request at the end of GAP.
   assign w_first = (r_state == ST_IDLE);
   assign w_wr    = w_first ? req_write : r_write;

   always_comb begin
      w_hdr     = '0;
      w_payload = '0;
      if (w_first) begin
         w_hdr     = w_wr ? HDR_WADDR : HDR_RADDR;
         w_payload = req_addr;
      end else begin
         w_hdr     = w_wr ? HDR_WDATA : HDR_RDATA;
         w_payload = w_wr ? r_wdata : '0;
      end
   end

   assign w_cnt_zero = (r_cnt == '0);

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_second_nxt   = r_second;
      w_capture      = 1'b0;
      w_load         = 1'b0;
      w_rx_en        = 1'b0;
      w_wr_done_nxt  = 1'b0;
      w_rd_valid_nxt = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_nxt = ST_ASSERT;
               w_capture   = 1'b1;
               w_load      = 1'b1;
            end
         end
         ST_ASSERT: begin
            w_state_nxt = ST_HDR;
            w_cnt_nxt   = C_HDR;
         end
         ST_HDR: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_PAYLOAD;
               w_cnt_nxt   = C_BITS;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_PAYLOAD: begin
            if (w_cnt_zero)
               w_state_nxt = ST_TAIL;
            else
               w_cnt_nxt = r_cnt - 1'b1;
         end
         ST_TAIL: begin
            if (r_second && !r_write) begin
               if (TURNAROUND > 0) begin
                  w_state_nxt = ST_TURN;
                  w_cnt_nxt   = C_TURN;
               end else begin
                  w_state_nxt = ST_RX;
                  w_cnt_nxt   = C_BITS;
               end
            end else begin
               w_state_nxt   = ST_GAP;
               w_cnt_nxt     = C_GAP;
               w_wr_done_nxt = r_second;
            end
         end
         ST_TURN: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_RX;
               w_cnt_nxt   = C_BITS;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_RX: begin
            w_rx_en = 1'b1;
            if (w_cnt_zero) begin
               w_state_nxt    = ST_GAP;
               w_cnt_nxt      = C_GAP;
               w_rd_valid_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_GAP: begin
            if (w_cnt_zero) begin
               if (r_second) begin
                  w_state_nxt  = ST_IDLE;
                  w_second_nxt = 1'b0;
               end else begin
                  w_state_nxt  = ST_ASSERT;
                  w_second_nxt = 1'b1;
                  w_load       = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_shift = (w_state_nxt == ST_HDR) ||
                    (w_state_nxt == ST_PAYLOAD);

   spi_bit_shifter #(.W(W)) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_frame   ({w_hdr, w_payload}),
      .i_shift   (w_shift),
      .o_msb     (w_msb),
      .i_rx_en   (w_rx_en),
      .i_rx_bit  (MISO),
      .o_rx_next (w_rx_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_second   <= 1'b0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_ss_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_wr_done  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_second   <= w_second_nxt;
         r_ss_n     <= (w_state_nxt == ST_IDLE) ||
                       (w_state_nxt == ST_GAP);
         r_mosi     <= w_shift ? w_msb : 1'b0;
         r_rd_valid <= w_rd_valid_nxt;
         r_wr_done  <= w_wr_done_nxt;
         if (w_capture) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_rd_valid_nxt)
            r_rd_data <= w_rx_next;
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign SS_n      = r_ss_n;
   assign MOSI      = r_mosi;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign wr_done   = r_wr_done;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized bench for spi_master_ctrl with an SPI RAM
// slave model and a frame-level behavioural reference.
module tb_spi_master_ctrl;

   localparam int W = 8;
   localparam int T = 2;
   localparam int G = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [7:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       req_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       wr_done;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO = 1'b0;

   spi_master_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .wr_done   (wr_done),
      .busy      (busy),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t",
                    nm, act, exp, $time);
   endtask

   function automatic logic [7:0] init_val(input int i);
      return 8'((i * 73) ^ 8'h5A);
   endfunction

   // ---------------- SPI RAM slave ----------------
   int         sk = 0;
   logic [10:0] ssh = '0;
   logic [7:0] s_addr = '0;
   logic [7:0] s_rbuf = '0;
   bit         s_rd = 0;
   bit         s_init = 0;
   logic [7:0] smem [256];
   logic [10:0] fq_bits[$];
   int         fq_len[$];

   always @(negedge clk) begin
      logic [2:0] idx;
      if (!s_init) begin
         for (int i = 0; i < 256; i++) smem[i] = init_val(i);
         s_init = 1;
      end
      if (SS_n === 1'b0) begin
         if (sk >= 1 && sk <= 11) ssh = {ssh[9:0], MOSI};
         if (sk == 11) begin
            case (ssh[10:8])
               3'b000: s_addr = ssh[7:0];
               3'b001: smem[s_addr] = ssh[7:0];
               3'b110: s_addr = ssh[7:0];
               3'b111: begin
                  s_rbuf = smem[s_addr];
                  s_rd = 1;
               end
               default: ;
            endcase
         end
         if (s_rd && sk >= 13 + T && sk < 13 + T + W) begin
            idx = 3'(W - 1 - (sk - 13 - T));
            MISO = s_rbuf[idx];
         end else begin
            MISO = 1'b0;
         end
         sk++;
      end else begin
         if (sk > 0) begin
            fq_bits.push_back(ssh);
            fq_len.push_back(sk);
         end
         sk = 0;
         ssh = '0;
         s_rd = 0;
         MISO = 1'b0;
      end
   end

   int wd_cnt = 0;
   always @(negedge clk) if (wr_done === 1'b1) wd_cnt++;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic ss;
      logic mosi;
      logic wd;
      logic rv;
   } ent_t;

   ent_t       mq[$];
   ent_t       cur = '{1'b1, 1'b0, 1'b0, 1'b0};
   bit         m_idle = 1;
   bit         m_started = 0;
   bit         m_init = 0;
   logic [7:0] m_rd = '0;
   logic [7:0] m_a = '0;
   logic [7:0] m_d = '0;
   logic [7:0] mmem [256];

   function automatic ent_t mk(input logic s, input logic m,
                               input logic w, input logic r);
      return {s, m, w, r};
   endfunction

   task automatic push_frame(input logic [2:0] h,
                             input logic [7:0] p,
                             input bit rx, input bit wd,
                             input bit rv);
      logic [10:0] b;
      b = {h, p};
      mq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 10; i >= 0; i--)
         mq.push_back(mk(1'b0, b[i], 1'b0, 1'b0));
      mq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      if (rx)
         for (int i = 0; i < T + W; i++)
            mq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      for (int g = 0; g < G; g++)
         mq.push_back(mk(1'b1, 1'b0, wd && g == 0,
                         rv && g == 0));
   endtask

   always @(posedge clk) begin
      if (!m_init) begin
         for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
         m_init = 1;
      end
      if (rst) begin
         mq.delete();
         m_idle = 1;
         m_rd = '0;
         m_started = 1;
         cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
      end else if (!m_started) begin
         cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
      end else if (m_idle) begin
         cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
         if (req_valid) begin
            m_a = req_addr;
            m_d = req_wdata;
            if (req_write) begin
               push_frame(3'b000, req_addr, 0, 0, 0);
               push_frame(3'b001, req_wdata, 0, 1, 0);
            end else begin
               push_frame(3'b110, req_addr, 0, 0, 0);
               push_frame(3'b111, 8'h00, 1, 0, 1);
            end
            m_idle = 0;
            cur = mq.pop_front();
         end
      end else if (mq.size() > 0) begin
         cur = mq.pop_front();
         if (cur.wd) mmem[m_a] = m_d;
         if (cur.rv) m_rd = mmem[m_a];
      end else begin
         m_idle = 1;
         cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
      end
   end

   task automatic compare_loop();
      logic [13:0] e;
      logic [13:0] a;
      forever begin
         @(negedge clk);
         if (m_started) begin
            e = {cur.ss, cur.mosi, !m_idle, m_idle,
                 cur.wd, cur.rv, m_rd};
            a = {SS_n, MOSI, busy, req_ready,
                 wr_done, rd_valid, rd_data};
            chk("cycle", 32'(a), 32'(e));
         end
      end
   endtask

   // ---------------- directed helpers ----------------
   task automatic do_req(input bit wr, input logic [7:0] a,
                         input logic [7:0] d,
                         output int lat_ev, output int lat_idle);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat_ev = -1;
      lat_idle = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if ((wr && wr_done) || (!wr && rd_valid)) lat_ev = n;
         if (req_ready) begin
            lat_idle = n;
            break;
         end
      end
   endtask

   task automatic wait_idle(input string nm);
      int ok;
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (req_ready) begin
            ok = 1;
            break;
         end
      end
      chk(nm, ok, 1);
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int le, li, hi, acc2, wd0;
      logic [10:0] fb;
      fork
         compare_loop();
      join_none
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ss_n", SS_n, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_wrd", wr_done, 0);
      chk("rst_rdata", rd_data, 0);
      rst = 1'b0;

      fq_bits.delete(); fq_len.delete();
      do_req(1, 8'hAA, 8'h55, le, li);
      chk("wr_done_lat", le, 27);
      chk("wr_idle_lat", li, 28);
      @(negedge clk);
      chk("wr_nframes", fq_bits.size(), 2);
      if (fq_bits.size() == 2) begin
         chk("waddr_frame", fq_bits[0], 11'b000_10101010);
         chk("wdata_frame", fq_bits[1], 11'b001_01010101);
         chk("waddr_len", fq_len[0], 13);
         chk("wdata_len", fq_len[1], 13);
      end

      fq_bits.delete(); fq_len.delete();
      do_req(0, 8'hAA, 8'h00, le, li);
      chk("rd_valid_lat", le, 37);
      chk("rd_idle_lat", li, 38);
      chk("rd_data_55", rd_data, 8'h55);
      @(negedge clk);
      chk("rd_nframes", fq_bits.size(), 2);
      if (fq_bits.size() == 2) begin
         chk("raddr_frame", fq_bits[0], 11'b110_10101010);
         chk("rdata_frame", fq_bits[1], 11'b111_00000000);
         chk("raddr_len", fq_len[0], 13);
         chk("rdata_len", fq_len[1], 23);
      end

      do_req(1, 8'h00, 8'hFF, le, li);
      do_req(1, 8'hFF, 8'h00, le, li);
      do_req(0, 8'h00, 8'h00, le, li);
      chk("rd_addr00", rd_data, 8'hFF);
      do_req(0, 8'hFF, 8'h00, le, li);
      chk("rd_addrFF", rd_data, 8'h00);

      // back-to-back with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 8'h10; req_wdata = 8'h3C;
      @(posedge clk);
      #1 req_write = 1'b0;
      hi = 0; acc2 = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (req_ready) hi++;
         else if (hi > 0) begin
            acc2 = n;
            break;
         end
      end
      req_valid = 1'b0;
      chk("b2b_ready_cycles", hi, 1);
      chk("b2b_accept_at", acc2, 29);
      chk("b2b_busy", busy, 1);
      wait_idle("b2b_idle");
      chk("b2b_rdata", rd_data, 8'h3C);

      // request pulsed while busy must be ignored
      fq_bits.delete(); fq_len.delete();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 8'h20; req_wdata = 8'h99;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 req_valid = 1'b1; req_write = 1'b0;
      req_addr = 8'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_idle("ign_idle");
      repeat (5) @(negedge clk);
      chk("ign_nframes", fq_bits.size(), 2);
      if (fq_bits.size() == 2) begin
         chk("ign_f0", fq_bits[0], 11'b000_00100000);
         chk("ign_f1", fq_bits[1], 11'b001_10011001);
      end

      // reset at k=6 of the WDATA frame
      wd0 = wd_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 8'h20; req_wdata = 8'h11;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("abort_ss_low", SS_n, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ss_high", SS_n, 1);
      chk("abort_ready", req_ready, 1);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_wr_done", wd_cnt, wd0);
      do_req(0, 8'h20, 8'h00, le, li);
      chk("abort_old_value", rd_data, 8'h99);

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         req_valid = ($urandom_range(0, 3) == 0);
         req_write = 1'($urandom_range(0, 1));
         req_addr  = ($urandom_range(0, 8) == 8) ?
                     8'hFF : 8'($urandom_range(0, 7));
         req_wdata = 8'($urandom);
      end
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle("rand_idle");
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
